// File: rtl/coarse_seq.sv
// Coarse switch-network sequencer: decodes rc_hi into the _DCn controls and drives the read counter to null the coarse error.
// Decode takes 1 cycle and pulses follow ref_pk_n by 2 cycles; there is no backpressure, so strobes outside their wait state are dropped.
module coarse_seq #(
    parameter int SETTLE_CYC = 16,
    parameter int AMB_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] rc_hi,
    input  logic       ref_pk_p,
    input  logic       ref_pk_n,
    input  logic       _TLC1H,
    input  logic       _ADHI,
    output logic       _DC1,
    output logic       _DC2,
    output logic       _DC3,
    output logic       _DC4,
    output logic       _DC5,
    output logic       _DC6,
    output logic       _DC7,
    output logic       _DC8,
    output logic       _DC9,
    output logic       _DC10,
    output logic       _DC11,
    output logic       _DC12,
    output logic       cnt_up,
    output logic       cnt_dn,
    output logic       coarse_err,
    output logic       amb
);

    localparam logic [7:0] SETTLE_LD = SETTLE_CYC[7:0];
    localparam logic [3:0] AMB_LIM   = AMB_LIMIT[3:0];

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        WAIT_P = 3'd2,
        WAIT_N = 3'd3,
        DECIDE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  settle_cnt, settle_cnt_nxt;
    logic [3:0]  amb_cnt, amb_cnt_nxt;
    logic        errp, errp_nxt;
    logic        errn, errn_nxt;
    logic        adhi_l, adhi_l_nxt;
    logic        up_nxt, dn_nxt, cerr_nxt, amb_nxt;
    logic        tlc_s1, tlc_s2, adhi_s1, adhi_s2;
    logic [6:0]  rc_prev;
    logic        rc_chg;
    logic [7:0]  sw_low;
    logic [11:0] dc_q, dc_nxt;

    assign rc_chg = (rc_hi != rc_prev);

    // Octant k selects the two summing-amp switches to close (bit n-1 = DCn).
    always_comb begin
        sw_low = 8'h00;
        case (rc_hi[6:4])
            3'd0:    sw_low = 8'b0001_0100;
            3'd1:    sw_low = 8'b0010_1000;
            3'd2:    sw_low = 8'b0010_0010;
            3'd3:    sw_low = 8'b0001_0001;
            3'd4:    sw_low = 8'b0100_0001;
            3'd5:    sw_low = 8'b1000_0010;
            3'd6:    sw_low = 8'b1000_1000;
            default: sw_low = 8'b0100_0100;
        endcase
        dc_nxt = {~rc_hi[0], ~rc_hi[1], ~rc_hi[2], ~rc_hi[3], ~sw_low};
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        amb_cnt_nxt    = amb_cnt;
        errp_nxt       = errp;
        errn_nxt       = errn;
        adhi_l_nxt     = adhi_l;
        amb_nxt        = amb;
        cerr_nxt       = coarse_err;
        up_nxt         = 1'b0;
        dn_nxt         = 1'b0;
        if (!en) begin
            state_nxt   = IDLE;
            amb_cnt_nxt = 4'd0;
            amb_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LD;
                end
                SETTLE: begin
                    if (rc_chg)
                        settle_cnt_nxt = SETTLE_LD;
                    else if (settle_cnt == 8'd0)
                        state_nxt = WAIT_P;
                    else
                        settle_cnt_nxt = settle_cnt - 8'd1;
                end
                WAIT_P: begin
                    if (rc_chg) begin
                        state_nxt      = SETTLE;
                        settle_cnt_nxt = SETTLE_LD;
                    end else if (ref_pk_p) begin
                        errp_nxt  = ~tlc_s2;
                        state_nxt = WAIT_N;
                    end
                end
                WAIT_N: begin
                    if (rc_chg) begin
                        state_nxt      = SETTLE;
                        settle_cnt_nxt = SETTLE_LD;
                    end else if (ref_pk_n) begin
                        errn_nxt   = ~tlc_s2;
                        adhi_l_nxt = adhi_s2;
                        state_nxt  = DECIDE;
                    end
                end
                DECIDE: begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LD;
                    cerr_nxt       = errp | errn;
                    if (errp) begin
                        up_nxt = 1'b1;
                    end else if (errn) begin
                        dn_nxt = 1'b1;
                    end else if (adhi_l) begin
                        // Persistent ambiguity with no error: force the counter upward.
                        if (amb_cnt + 4'd1 == AMB_LIM) begin
                            up_nxt      = 1'b1;
                            amb_nxt     = 1'b1;
                            amb_cnt_nxt = 4'd0;
                        end else begin
                            amb_cnt_nxt = amb_cnt + 4'd1;
                        end
                    end else begin
                        amb_cnt_nxt = 4'd0;
                        amb_nxt     = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            amb_cnt    <= 4'd0;
            errp       <= 1'b0;
            errn       <= 1'b0;
            adhi_l     <= 1'b0;
            cnt_up     <= 1'b0;
            cnt_dn     <= 1'b0;
            coarse_err <= 1'b0;
            amb        <= 1'b0;
            tlc_s1     <= 1'b1;
            tlc_s2     <= 1'b1;
            adhi_s1    <= 1'b0;
            adhi_s2    <= 1'b0;
            rc_prev    <= 7'd0;
            dc_q       <= 12'hFFF;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            amb_cnt    <= amb_cnt_nxt;
            errp       <= errp_nxt;
            errn       <= errn_nxt;
            adhi_l     <= adhi_l_nxt;
            cnt_up     <= up_nxt;
            cnt_dn     <= dn_nxt;
            coarse_err <= cerr_nxt;
            amb        <= amb_nxt;
            tlc_s1     <= _TLC1H;
            tlc_s2     <= tlc_s1;
            adhi_s1    <= _ADHI;
            adhi_s2    <= adhi_s1;
            rc_prev    <= rc_hi;
            dc_q       <= dc_nxt;
        end
    end

    assign _DC1  = dc_q[0];
    assign _DC2  = dc_q[1];
    assign _DC3  = dc_q[2];
    assign _DC4  = dc_q[3];
    assign _DC5  = dc_q[4];
    assign _DC6  = dc_q[5];
    assign _DC7  = dc_q[6];
    assign _DC8  = dc_q[7];
    assign _DC9  = dc_q[8];
    assign _DC10 = dc_q[9];
    assign _DC11 = dc_q[10];
    assign _DC12 = dc_q[11];

endmodule

// File: tb/tb_coarse_seq.sv
// Directed and randomized windows for coarse_seq, checked against a window-level model of the coarse loop.
module tb_coarse_seq;

    localparam int SETTLE = 16;
    localparam int AMBL   = 4;

    logic       clk = 1'b0;
    logic       rst, en, ref_pk_p, ref_pk_n, tlc_in, adhi_in;
    logic [6:0] rc_hi;
    logic       dc1, dc2, dc3, dc4, dc5, dc6, dc7, dc8, dc9, dc10, dc11, dc12;
    logic       cnt_up, cnt_dn, coarse_err, amb;
    logic [11:0] dcv;

    int checks = 0;
    int errors = 0;
    int up_cd  = 0;
    int dn_cd  = 0;
    int m_amb_cnt = 0;
    bit m_amb  = 1'b0;
    bit m_cerr = 1'b0;

    assign dcv = {dc12, dc11, dc10, dc9, dc8, dc7, dc6, dc5, dc4, dc3, dc2, dc1};

    coarse_seq #(.SETTLE_CYC(SETTLE), .AMB_LIMIT(AMBL)) dut (
        .clk(clk), .rst(rst), .en(en), .rc_hi(rc_hi),
        .ref_pk_p(ref_pk_p), .ref_pk_n(ref_pk_n),
        ._TLC1H(tlc_in), ._ADHI(adhi_in),
        ._DC1(dc1), ._DC2(dc2), ._DC3(dc3), ._DC4(dc4), ._DC5(dc5), ._DC6(dc6),
        ._DC7(dc7), ._DC8(dc8), ._DC9(dc9), ._DC10(dc10), ._DC11(dc11), ._DC12(dc12),
        .cnt_up(cnt_up), .cnt_dn(cnt_dn), .coarse_err(coarse_err), .amb(amb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected switch vector, bit n-1 = _DCn, from the octant switch-pair table.
    function automatic logic [11:0] dc_exp(input logic [6:0] rc);
        int pa[8] = '{3, 4, 2, 1, 1, 2, 4, 3};
        int pb[8] = '{5, 6, 6, 5, 7, 8, 8, 7};
        logic [11:0] v;
        int k;
        v = '1;
        k = int'(rc[6:4]);
        v[pa[k]-1] = 1'b0;
        v[pb[k]-1] = 1'b0;
        for (int b = 0; b < 4; b++) v[8+b] = ~rc[3-b];
        return v;
    endfunction

    // One clock; checks decode and pulse schedule, and models the read counter.
    task automatic tick();
        logic [6:0] rc_e;
        logic       rst_e, eu, ed;
        rc_e  = rc_hi;
        rst_e = rst;
        @(posedge clk);
        #1;
        chk("dc_decode", dcv, rst_e ? 12'hFFF : dc_exp(rc_e));
        eu = 1'b0;
        ed = 1'b0;
        if (up_cd > 0) begin up_cd--; eu = (up_cd == 0); end
        if (dn_cd > 0) begin dn_cd--; ed = (dn_cd == 0); end
        chk("cnt_up", cnt_up, eu);
        chk("cnt_dn", cnt_dn, ed);
        if (eu) rc_hi = rc_hi + 7'd1;
        if (ed) rc_hi = rc_hi - 7'd1;
    endtask

    task automatic predict(input bit ep, input bit en_, input bit ad);
        if (ep) up_cd = 2;
        else if (en_) dn_cd = 2;
        else if (ad) begin
            m_amb_cnt++;
            if (m_amb_cnt == AMBL) begin
                up_cd = 2;
                m_amb = 1'b1;
                m_amb_cnt = 0;
            end
        end else begin
            m_amb_cnt = 0;
            m_amb = 1'b0;
        end
        m_cerr = ep | en_;
    endtask

    // mode 0: normal, 1: both strobes together in WAIT_P, 2: stray ref_pk_n before ref_pk_p
    task automatic window(input bit ep, input bit en_, input bit ad, input int mode);
        repeat (SETTLE + 6 + $urandom_range(0, 6)) tick();
        tlc_in  = ~ep;
        adhi_in = $urandom_range(0, 1);
        repeat (3) tick();
        if (mode == 2) begin
            ref_pk_n = 1'b1; tick(); ref_pk_n = 1'b0;
        end
        ref_pk_p = 1'b1;
        if (mode == 1) ref_pk_n = 1'b1;
        tick();
        ref_pk_p = 1'b0;
        ref_pk_n = 1'b0;
        tlc_in  = ~en_;
        adhi_in = ad;
        repeat (3 + $urandom_range(0, 4)) tick();
        ref_pk_n = 1'b1;
        predict(ep, en_, ad);
        tick();
        ref_pk_n = 1'b0;
        tick();
        chk("coarse_err", coarse_err, m_cerr);
        chk("amb", amb, m_amb);
    endtask

    // Strobes with a low detect shortly after a pulse or abort must be ignored while settling.
    task automatic early_strobes();
        repeat (2) tick();
        tlc_in = 1'b0;
        ref_pk_p = 1'b1; tick(); ref_pk_p = 1'b0;
        tick();
        ref_pk_n = 1'b1; tick(); ref_pk_n = 1'b0;
        repeat (3) tick();
        tlc_in = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rc_hi = 7'h00;
        ref_pk_p = 1'b0; ref_pk_n = 1'b0; tlc_in = 1'b1; adhi_in = 1'b0;
        repeat (3) tick();
        chk("rst_cnt_up", cnt_up, 1'b0);
        chk("rst_cnt_dn", cnt_dn, 1'b0);
        chk("rst_coarse_err", coarse_err, 1'b0);
        chk("rst_amb", amb, 1'b0);
        rst = 1'b0;
        tick();
        chk("dc_k0_after_rst", dcv, 12'hFEB);

        rc_hi = 7'h5A;
        tick();
        chk("dc_5a", dcv, 12'hA7D);
        tlc_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ref_pk_p = $urandom_range(0, 1);
            ref_pk_n = $urandom_range(0, 1);
            adhi_in  = $urandom_range(0, 1);
            tick();
        end
        ref_pk_p = 1'b0; ref_pk_n = 1'b0; tlc_in = 1'b1; adhi_in = 1'b0;

        en = 1'b1;
        window(1, 0, 0, 0);
        early_strobes();
        window(0, 1, 0, 0);
        window(0, 0, 0, 0);

        for (int i = 0; i < AMBL; i++) window(0, 0, 1, 0);
        window(1, 0, 0, 0);
        window(0, 0, 0, 0);

        window(1, 0, 0, 1);
        window(0, 1, 0, 2);

        // Abort: rc_hi moves between the strobes.
        repeat (SETTLE + 6) tick();
        tlc_in = 1'b0;
        repeat (3) tick();
        ref_pk_p = 1'b1; tick(); ref_pk_p = 1'b0;
        rc_hi = rc_hi + 7'd3;
        repeat (3) tick();
        ref_pk_n = 1'b1; tick(); ref_pk_n = 1'b0;
        repeat (2) tick();
        early_strobes();
        window(0, 1, 0, 0);

        // Disable while DECIDE is pending.
        for (int i = 0; i < AMBL; i++) window(0, 0, 1, 0);
        repeat (SETTLE + 6) tick();
        tlc_in = 1'b0;
        repeat (3) tick();
        ref_pk_p = 1'b1; tick(); ref_pk_p = 1'b0;
        repeat (3) tick();
        ref_pk_n = 1'b1; tick(); ref_pk_n = 1'b0;
        en = 1'b0;
        tick();
        m_amb = 1'b0;
        m_amb_cnt = 0;
        chk("amb_after_disable", amb, 1'b0);
        repeat (3) tick();
        en = 1'b1;
        tlc_in = 1'b1;
        for (int i = 0; i < AMBL - 1; i++) window(0, 0, 1, 0);
        window(0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            window($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 2));
        end
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
